// File: rtl/chany_retime_1__3__if.sv
// Channel bundle for the column-1/row-3 vertical retiming stage.
// The master side drives the incoming tracks; the slave side (the retimer) drives the outgoing ones.
interface chany_retime_1__3__if #(
  parameter int CHAN_WIDTH = 20
);
  logic [0:CHAN_WIDTH-1] chany_bottom_in;
  logic [0:CHAN_WIDTH-1] chany_top_in;
  logic [0:CHAN_WIDTH-1] chany_top_out;
  logic [0:CHAN_WIDTH-1] chany_bottom_out;

  modport master (
    output chany_bottom_in,
    output chany_top_in,
    input  chany_top_out,
    input  chany_bottom_out
  );

  modport slave (
    input  chany_bottom_in,
    input  chany_top_in,
    output chany_top_out,
    output chany_bottom_out
  );
endinterface

// File: rtl/chany_retime_1__3_.sv
// Per-track retiming stage for the column-1/row-3 vertical channel: each track in each direction
// is either bypassed or delayed one cycle, as selected by a shadowed 40-bit config shift chain.
module chany_retime_1__3_ #(
  parameter int CHAN_WIDTH = 20,
  parameter int CFG_BITS   = 2 * CHAN_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_shift_en,
  input  logic                     cfg_load,
  input  logic                     ccff_head,
  output logic                     ccff_tail,
  output logic                     cfg_aligned,
  chany_retime_1__3__if.slave      chan
);

  localparam logic [5:0] CNT_LAST = 6'(CFG_BITS - 1);

  logic [CFG_BITS-1:0]   chain_q, chain_d;
  logic [CFG_BITS-1:0]   act_q, act_d;
  logic [0:CHAN_WIDTH-1] nreg_q, nreg_d;
  logic [0:CHAN_WIDTH-1] sreg_q, sreg_d;
  logic [5:0]            count_q, count_d;

  always_comb begin
    chain_d = chain_q;
    count_d = count_q;
    if (cfg_shift_en) begin
      chain_d = {chain_q[CFG_BITS-2:0], ccff_head};
      count_d = (count_q == CNT_LAST) ? 6'd0 : count_q + 6'd1;
    end
  end

  // Load samples the chain as it stood before this edge's shift.
  always_comb begin
    act_d = act_q;
    if (cfg_load) begin
      act_d = chain_q;
    end
  end

  always_comb begin
    nreg_d = chan.chany_bottom_in;
    sreg_d = chan.chany_top_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
      act_q   <= '0;
      nreg_q  <= '0;
      sreg_q  <= '0;
      count_q <= '0;
    end else begin
      chain_q <= chain_d;
      act_q   <= act_d;
      nreg_q  <= nreg_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
    end
  end

  assign ccff_tail   = chain_q[CFG_BITS-1];
  assign cfg_aligned = (count_q == 6'd0);

  // Low half of act steers northbound tracks, high half southbound.
  genvar gi;
  generate
    for (gi = 0; gi < CHAN_WIDTH; gi++) begin : g_track
      assign chan.chany_top_out[gi]    = act_q[gi] ? nreg_q[gi] : chan.chany_bottom_in[gi];
      assign chan.chany_bottom_out[gi] = act_q[CHAN_WIDTH + gi] ? sreg_q[gi] : chan.chany_top_in[gi];
    end
  endgenerate

endmodule

// File: tb/tb_chany_retime_1__3_.sv
// Scoreboard bench for chany_retime_1__3_: the stimulus side queues the expected outputs for each
// cycle, and an independent monitor compares them against the DUT shortly after every falling edge.
module tb_chany_retime_1__3_;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_shift_en = 1'b0;
  logic cfg_load = 1'b0;
  logic ccff_head = 1'b0;
  logic ccff_tail;
  logic cfg_aligned;

  chany_retime_1__3__if chan ();

  chany_retime_1__3_ dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_shift_en (cfg_shift_en),
    .cfg_load     (cfg_load),
    .ccff_head    (ccff_head),
    .ccff_tail    (ccff_tail),
    .cfg_aligned  (cfg_aligned),
    .chan         (chan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:19] top;
    logic [0:19] bot;
    logic        tail;
    logic        aligned;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Expected-state tracking: chain/act contents, last captured inputs, shift count.
  logic [39:0] m_chain = '0;
  logic [39:0] m_act   = '0;
  logic [0:19] m_prev_b = '0;
  logic [0:19] m_prev_t = '0;
  int          m_cnt = 0;

  function automatic exp_t predict(input logic [0:19] b, input logic [0:19] t, input string nm);
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      e.top[i] = m_act[i]      ? m_prev_b[i] : b[i];
      e.bot[i] = m_act[20 + i] ? m_prev_t[i] : t[i];
    end
    e.tail    = m_chain[39];
    e.aligned = (m_cnt == 0);
    e.name    = nm;
    return e;
  endfunction

  task automatic step(input logic [0:19] b, input logic [0:19] t,
                      input logic sh, input logic ld, input logic hd, input string nm);
    @(negedge clk);
    reset_n = 1'b1;
    chan.chany_bottom_in = b;
    chan.chany_top_in    = t;
    cfg_shift_en = sh;
    cfg_load     = ld;
    ccff_head    = hd;
    exp_q.push_back(predict(b, t, nm));
    if (ld) m_act = m_chain;
    if (sh) begin
      m_chain = {m_chain[38:0], hd};
      m_cnt   = (m_cnt == 39) ? 0 : m_cnt + 1;
    end
    m_prev_b = b;
    m_prev_t = t;
  endtask

  // Reset asserted between clock edges, with config controls still active.
  task automatic rst_cycle(input logic [0:19] b, input logic [0:19] t, input string nm);
    @(negedge clk);
    reset_n = 1'b0;
    chan.chany_bottom_in = b;
    chan.chany_top_in    = t;
    cfg_shift_en = 1'b1;
    cfg_load     = 1'b1;
    ccff_head    = 1'b1;
    m_chain  = '0;
    m_act    = '0;
    m_prev_b = '0;
    m_prev_t = '0;
    m_cnt    = 0;
    exp_q.push_back(predict(b, t, nm));
  endtask

  function automatic logic [0:19] pat(input int j);
    logic [19:0] v;
    v = 20'(j * 32'h0001_3579) ^ 20'hC3A5F;
    return v;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if (chan.chany_top_out !== e.top || chan.chany_bottom_out !== e.bot ||
            ccff_tail !== e.tail || cfg_aligned !== e.aligned) begin
          n_mismatched++;
          $display("FAIL %s: got top=%h bot=%h tail=%b aligned=%b, want top=%h bot=%h tail=%b aligned=%b",
                   e.name, chan.chany_top_out, chan.chany_bottom_out, ccff_tail, cfg_aligned,
                   e.top, e.bot, e.tail, e.aligned);
        end
      end
    end
  end

  initial begin : stimulus
    chan.chany_bottom_in = 20'hA5A5A;
    chan.chany_top_in    = 20'h5A5A5;

    // Reset state and pure bypass
    rst_cycle(20'hA5A5A, 20'h5A5A5, "reset_bypass");
    rst_cycle(20'h12345, 20'hFEDCB, "reset_bypass_b");
    step(20'hA5A5A, 20'h5A5A5, 1'b0, 1'b0, 1'b0, "post_reset_bypass");
    step(20'h0F0F0, 20'hF0F0F, 1'b0, 1'b0, 1'b0, "bypass_pattern2");
    step(20'hFFFFF, 20'h00000, 1'b0, 1'b0, 1'b0, "bypass_pattern3");

    // 40 shifts: first 20 zeros land in bits 39..20, last 20 ones in bits 19..0
    for (int j = 0; j < 40; j++)
      step(pat(j), ~pat(j), 1'b1, 1'b0, (j >= 20), $sformatf("shift_n_%0d", j));
    step(20'h11111, 20'h22222, 1'b0, 1'b1, 1'b0, "load_north_reg");
    for (int j = 0; j < 6; j++)
      step(pat(100 + j), pat(200 + j), 1'b0, 1'b0, 1'b0, $sformatf("north_reg_%0d", j));

    // Alternating pattern from a clean reset; never loaded, so datapath stays bypass
    rst_cycle(20'hABCDE, 20'h13579, "reset_before_alt");
    for (int j = 0; j < 46; j++)
      step(pat(300 + j), pat(400 + j), 1'b1, 1'b0, j[0], $sformatf("alt_shift_%0d", j));

    // 80 shifts of ones: aligned only after 40 and 80, count wraps
    rst_cycle(20'h00000, 20'hFFFFF, "reset_before_80");
    for (int j = 0; j < 80; j++)
      step(pat(500 + j), pat(600 + j), 1'b1, 1'b0, 1'b1, $sformatf("shift80_%0d", j));

    // Simultaneous shift+load with chain all ones and head 0
    step(20'h33333, 20'h44444, 1'b1, 1'b1, 1'b0, "shift_and_load");
    for (int j = 0; j < 5; j++)
      step(pat(700 + j), pat(800 + j), 1'b0, 1'b0, 1'b0, $sformatf("all_reg_%0d", j));
    for (int j = 0; j < 39; j++)
      step(pat(900 + j), pat(950 + j), 1'b1, 1'b0, 1'b1, $sformatf("zero_walk_%0d", j));

    // Mid-sequence reset with all tracks registered
    for (int j = 0; j < 17; j++)
      step(pat(1000 + j), pat(1100 + j), 1'b1, 1'b0, 1'b0, $sformatf("pre_reset_shift_%0d", j));
    rst_cycle(20'h5A5A5, 20'hA5A5A, "mid_shift_reset");
    rst_cycle(20'h6B6B6, 20'hB6B6B, "mid_shift_reset_hold");
    for (int j = 0; j < 40; j++)
      step(pat(1200 + j), pat(1300 + j), 1'b1, 1'b0, (j >= 20), $sformatf("reshift_%0d", j));
    step(20'h77777, 20'h88888, 1'b0, 1'b1, 1'b0, "reload_north_reg");
    for (int j = 0; j < 6; j++)
      step(pat(1400 + j), pat(1500 + j), 1'b0, 1'b0, 1'b0, $sformatf("re_north_reg_%0d", j));

    repeat (3) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
